// File: rtl/sha256_msg_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_sched_pkg
// Description : Shared constants and state encoding for the SHA-256
//               message-schedule expander.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_msg_sched_pkg;

    localparam int SHA256_BLOCK_WORDS = 16;
    localparam int SHA256_ROUNDS      = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2
    } sha2_sched_state_e;

endpackage
`default_nettype wire

// File: rtl/sha256_sched_sigma.sv
`default_nettype none
// ============================================================================
// Module      : sha256_sched_sigma
// Description : Combinational SHA-256 small-sigma pair used by the message
//               schedule: sig0 on x0_i and sig1 on x1_i.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_sched_sigma (
    input  logic [31:0] x0_i,
    input  logic [31:0] x1_i,
    output logic [31:0] sig0_o,
    output logic [31:0] sig1_o
);

    // sig0 = ROTR7 ^ ROTR18 ^ SHR3
    assign sig0_o = {x0_i[6:0],  x0_i[31:7]}
                  ^ {x0_i[17:0], x0_i[31:18]}
                  ^ (x0_i >> 3);

    // sig1 = ROTR17 ^ ROTR19 ^ SHR10
    assign sig1_o = {x1_i[16:0], x1_i[31:17]}
                  ^ {x1_i[18:0], x1_i[31:19]}
                  ^ (x1_i >> 10);

endmodule
`default_nettype wire

// File: rtl/sha256_msg_sched.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_sched
// Description : SHA-256 message-schedule expander. Takes W[0..15] of one
//               block on a valid/ready input, emits W[0..ROUNDS-1] in order
//               through a single-entry registered valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_sched
    import sha256_msg_sched_pkg::*;
#(
    parameter  int ROUNDS = SHA256_ROUNDS,
    localparam int IDX_W  = $clog2(ROUNDS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             w_in_valid_i,
    output logic             w_in_ready_o,
    input  logic [31:0]      w_in_i,
    output logic             w_out_valid_o,
    input  logic             w_out_ready_i,
    output logic [31:0]      w_out_o,
    output logic [IDX_W-1:0] w_out_idx_o,
    output logic             w_out_last_o,
    output logic             busy_o
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] c_load_end = IDX_W'(SHA256_BLOCK_WORDS - 1);
    localparam bit               c_has_exp  = (ROUNDS > SHA256_BLOCK_WORDS);

    sha2_sched_state_e state_q, state_d;
    logic [31:0]       window_q [SHA256_BLOCK_WORDS];
    logic [31:0]       window_d [SHA256_BLOCK_WORDS];
    logic [IDX_W-1:0]  t_q, t_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_word_q, out_word_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic              out_last_q, out_last_d;

    logic              w_can_load;
    logic              w_last_pending;
    logic              w_in_ready;
    logic              w_push;
    logic [31:0]       w_push_word;
    logic [31:0]       w_sig0;
    logic [31:0]       w_sig1;
    logic [31:0]       w_new_word;

    // Window taps: window[0]=W[t-16], window[1]=W[t-15], window[9]=W[t-7],
    // window[14]=W[t-2].
    sha256_sched_sigma u_sigma (
        .x0_i   (window_q[1]),
        .x1_i   (window_q[14]),
        .sig0_o (w_sig0),
        .sig1_o (w_sig1)
    );

    assign w_new_word     = w_sig1 + window_q[9] + w_sig0 + window_q[0];
    assign w_can_load     = !out_valid_q || w_out_ready_i;
    // Final word is sitting in the output register: issue nothing more.
    assign w_last_pending = out_valid_q && out_last_q;

    // Next-state, window shift, counter and output-register load logic.
    always_comb begin
        state_d     = state_q;
        window_d    = window_q;
        t_d         = t_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        w_in_ready  = 1'b0;
        w_push      = 1'b0;
        w_push_word = w_new_word;

        // Drain: downstream took the current word.
        if (out_valid_q && w_out_ready_i) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    t_d     = '0;
                end
            end
            LOAD: begin
                if (w_last_pending) begin
                    if (w_out_ready_i) begin
                        state_d = IDLE;
                    end
                end else begin
                    w_in_ready = w_can_load;
                    if (w_in_valid_i && w_can_load) begin
                        w_push      = 1'b1;
                        w_push_word = w_in_i;
                        if (t_q == c_load_end && c_has_exp) begin
                            state_d = EXPAND;
                        end
                    end
                end
            end
            EXPAND: begin
                if (w_last_pending) begin
                    if (w_out_ready_i) begin
                        state_d = IDLE;
                    end
                end else if (w_can_load) begin
                    w_push      = 1'b1;
                    w_push_word = w_new_word;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_push) begin
            for (int i = 0; i < SHA256_BLOCK_WORDS - 1; i++) begin
                window_d[i] = window_q[i+1];
            end
            window_d[SHA256_BLOCK_WORDS-1] = w_push_word;
            out_valid_d = 1'b1;
            out_word_d  = w_push_word;
            out_idx_d   = t_q;
            out_last_d  = (t_q == c_last_idx);
            t_d         = t_q + IDX_W'(1);
        end
    end

    // State, window, counter and output register flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            t_q         <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < SHA256_BLOCK_WORDS; i++) begin
                window_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            window_q    <= window_d;
        end
    end

    assign w_in_ready_o  = w_in_ready;
    assign w_out_valid_o = out_valid_q;
    assign w_out_o       = out_word_q;
    assign w_out_idx_o   = out_idx_q;
    assign w_out_last_o  = out_last_q;
    assign busy_o        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sha256_msg_sched
// Description : Self-checking bench for sha256_msg_sched (ROUNDS=64 and 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_sched;

    localparam int R = 64;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i = 1'b1, start_i = 1'b0, w_in_valid_i = 1'b0, w_out_ready_i = 1'b0;
    logic [31:0] w_in_i = '0;
    logic        w_in_ready_o, w_out_valid_o, w_out_last_o, busy_o;
    logic [31:0] w_out_o;
    logic [5:0]  w_out_idx_o;

    logic        start16 = 1'b0, in_valid16 = 1'b0, out_ready16 = 1'b0;
    logic [31:0] w_in16 = '0;
    logic        in_ready16, out_valid16, out_last16, busy16;
    logic [31:0] w_out16;
    logic [3:0]  idx16;

    sha256_msg_sched #(.ROUNDS(64)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .w_in_valid_i(w_in_valid_i), .w_in_ready_o(w_in_ready_o), .w_in_i(w_in_i),
        .w_out_valid_o(w_out_valid_o), .w_out_ready_i(w_out_ready_i), .w_out_o(w_out_o),
        .w_out_idx_o(w_out_idx_o), .w_out_last_o(w_out_last_o), .busy_o(busy_o)
    );

    sha256_msg_sched #(.ROUNDS(16)) dut16 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start16),
        .w_in_valid_i(in_valid16), .w_in_ready_o(in_ready16), .w_in_i(w_in16),
        .w_out_valid_o(out_valid16), .w_out_ready_i(out_ready16), .w_out_o(w_out16),
        .w_out_idx_o(idx16), .w_out_last_o(out_last16), .busy_o(busy16)
    );

    int          checks = 0;
    int          passes = 0;
    bit [31:0]   blk   [16];
    bit [31:0]   exp_w [R];
    logic [31:0] got_w [R];
    int          got_idx [R];
    logic        got_last [R];
    int          got_n = 0;
    bit          mon_en = 1'b0;
    logic [31:0] cap_w [2][R];

    typedef struct {
        string       name;
        int          kind;   // 0 = "abc" block, 1 = all-ones block
        int          idx;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    function automatic bit [31:0] rotr(input bit [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule straight from the recurrence on a flat array.
    function automatic void build_model();
        bit [31:0] s0, s1;
        for (int t = 0; t < R; t++) begin
            if (t < 16) begin
                exp_w[t] = blk[t];
            end else begin
                s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
                s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
                exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
            end
        end
    endfunction

    function automatic void set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endfunction

    // Output monitor: a word is accepted at the next rising edge.
    always @(negedge clk) begin
        if (mon_en && !rst_i && w_out_valid_o && w_out_ready_i) begin
            if (got_n < R) begin
                got_w[got_n]    = w_out_o;
                got_idx[got_n]  = int'(w_out_idx_o);
                got_last[got_n] = w_out_last_o;
            end
            got_n++;
        end
    end

    // gap_mode: 0 continuous, 1 toggling input valid, 2 random valid/ready.
    task automatic run_block(input int gap_mode, input int bp_idx, input int bp_len,
                             input int start_at, input int rst_at, input string tag);
        int k = 0, bp_cnt = 0, cyc = 0;
        bit in_hs, hold, toggle = 1'b0;
        build_model();
        got_n  = 0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b1; w_out_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk1({tag, "_busy_start"}, busy_o, 1'b1);
        forever begin
            toggle = ~toggle;
            w_in_valid_i = (k < 16) && (gap_mode == 0 || (gap_mode == 1 && toggle) ||
                                        (gap_mode == 2 && $urandom_range(0, 1) == 1));
            w_in_i = blk[(k < 16) ? k : 15];
            hold = w_out_valid_o && int'(w_out_idx_o) == bp_idx && bp_cnt < bp_len;
            if (hold) w_out_ready_i = 1'b0;
            else if (gap_mode == 2) w_out_ready_i = ($urandom_range(0, 3) != 0);
            else w_out_ready_i = 1'b1;
            start_i = (start_at >= 0) && w_out_valid_o && int'(w_out_idx_o) == start_at;
            if (rst_at >= 0 && w_out_valid_o && int'(w_out_idx_o) == rst_at) begin
                rst_i = 1'b1;
                @(posedge clk); #1;
                rst_i = 1'b0; start_i = 1'b0; w_in_valid_i = 1'b0;
                chk1 ({tag, "_rst_valid"}, w_out_valid_o, 1'b0);
                chk32({tag, "_rst_word"},  w_out_o, 32'h0);
                chk32({tag, "_rst_idx"},   32'(w_out_idx_o), 32'h0);
                chk1 ({tag, "_rst_last"},  w_out_last_o, 1'b0);
                chk1 ({tag, "_rst_busy"},  busy_o, 1'b0);
                chk1 ({tag, "_rst_inrdy"}, w_in_ready_o, 1'b0);
                mon_en = 1'b0;
                return;
            end
            #1;
            if (hold) begin
                bp_cnt++;
                chk32({tag, "_hold_word"}, w_out_o, exp_w[bp_idx]);
                chk32({tag, "_hold_idx"},  32'(w_out_idx_o), 32'(bp_idx));
                chk1 ({tag, "_hold_valid"}, w_out_valid_o, 1'b1);
                chk1 ({tag, "_hold_inrdy"}, w_in_ready_o, 1'b0);
            end
            @(negedge clk);
            in_hs = w_in_valid_i && w_in_ready_o;
            @(posedge clk); #1;
            if (in_hs) k++;
            cyc++;
            if (got_n >= R) break;
            if (cyc > 2000) begin
                $display("FAIL %s_timeout: %0d words seen, %0d required", tag, got_n, R);
                checks++;
                break;
            end
        end
        w_in_valid_i = 1'b0; start_i = 1'b0;
        chk1({tag, "_busy_end"},  busy_o, 1'b0);
        chk1({tag, "_valid_end"}, w_out_valid_o, 1'b0);
        mon_en = 1'b0;
        chk32({tag, "_count"}, got_n, R);
        for (int i = 0; i < R && i < got_n; i++) begin
            chk32($sformatf("%s_idx%0d", tag, i),  got_idx[i], i);
            chk32($sformatf("%s_word%0d", tag, i), got_w[i], exp_w[i]);
            chk1 ($sformatf("%s_last%0d", tag, i), got_last[i], i == R - 1);
        end
    endtask

    task automatic run16();
        int n = 0, k = 0, cyc = 0;
        @(posedge clk); #1;
        start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0; out_ready16 = 1'b1;
        while (cyc < 200) begin
            in_valid16 = (k < 16);
            w_in16     = blk[(k < 16) ? k : 15];
            @(negedge clk);
            if (in_valid16 && in_ready16) k++;
            if (out_valid16 && out_ready16) begin
                chk32($sformatf("r16_word%0d", n), w_out16, blk[n < 16 ? n : 15]);
                chk32($sformatf("r16_idx%0d", n), 32'(idx16), n);
                chk1 ($sformatf("r16_last%0d", n), out_last16, n == 15);
                n++;
            end
            @(posedge clk); #1;
            cyc++;
            if (n >= 16) break;
        end
        in_valid16 = 1'b0;
        chk32("r16_count", n, 16);
        chk1("r16_busy_end", busy16, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk1("r16_no_extra", out_valid16, 1'b0);
    endtask

    initial begin
        vecs[0] = '{"abc_w0",    0, 0,  32'h61626380};
        vecs[1] = '{"abc_w1",    0, 1,  32'h00000000};
        vecs[2] = '{"abc_w15",   0, 15, 32'h00000018};
        vecs[3] = '{"abc_w16",   0, 16, 32'h61626380};
        vecs[4] = '{"abc_w17",   0, 17, 32'h000F0000};
        vecs[5] = '{"ones_w0",   1, 0,  32'hFFFFFFFF};
        vecs[6] = '{"ones_w15",  1, 15, 32'hFFFFFFFF};
        vecs[7] = '{"ones_w16",  1, 16, 32'h203FFFFC};

        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk1 ("reset_valid", w_out_valid_o, 1'b0);
        chk32("reset_word",  w_out_o, 32'h0);
        chk32("reset_idx",   32'(w_out_idx_o), 32'h0);
        chk1 ("reset_last",  w_out_last_o, 1'b0);
        chk1 ("reset_busy",  busy_o, 1'b0);
        chk1 ("reset_inrdy", w_in_ready_o, 1'b0);

        // Input valid in IDLE must not be accepted.
        w_in_valid_i = 1'b1; w_in_i = 32'h12345678; w_out_ready_i = 1'b1;
        #1;
        chk1("idle_inrdy", w_in_ready_o, 1'b0);
        @(posedge clk); #1;
        w_in_valid_i = 1'b0;
        chk1("idle_no_valid", w_out_valid_o, 1'b0);
        chk1("idle_no_busy",  busy_o, 1'b0);

        set_abc();
        run_block(0, -1, 0, -1, -1, "abc");
        for (int i = 0; i < R; i++) cap_w[0][i] = got_w[i];
        for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
        run_block(0, -1, 0, -1, -1, "ones");
        for (int i = 0; i < R; i++) cap_w[1][i] = got_w[i];

        for (int v = 0; v < 8; v++) begin
            chk32(vecs[v].name, cap_w[vecs[v].kind][vecs[v].idx], vecs[v].exp);
        end

        set_abc();
        run_block(0, 20, 5, -1, -1, "bp20");
        run_block(1, 3, 4, -1, -1, "loadgap");
        run_block(0, -1, 0, 10, -1, "start10");
        run_block(0, -1, 0, -1, 30, "rst30");
        run_block(0, -1, 0, -1, -1, "after_rst");

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) blk[i] = $urandom();
            run_block(2, $urandom_range(0, 63), $urandom_range(1, 6), -1, -1,
                      $sformatf("rand%0d", r));
        end

        set_abc();
        run16();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
